// File: rtl/hight_key_schedule.sv
// hight_key_schedule: streams HIGHT whitening keys and per-round subkeys from a 128-bit master key.
// Optional HIGHT_KS_ZEROIZE_EN clears key material on completion.
module hight_key_schedule #(
  parameter int ROUNDS = 32,
  parameter logic [6:0] DELTA0 = 7'h5A
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] mk,
  input  logic         ed,
  output logic         busy,
  output logic [63:0]  wk,
  output logic         sk_valid,
  input  logic         sk_ready,
  output logic [4:0]   sk_round,
  output logic [31:0]  sk,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [127:0] mk_q;
  logic         ed_q;
  logic [6:0]   lfsr, lfsr_nx;
  logic [4:0]   rnd;
  logic [6:0]   dl [4];
  logic [2:0]   j;
  logic         last;

  function automatic logic [6:0] fwd(input logic [6:0] d);
    return {d[3] ^ d[0], d[6:1]};
  endfunction

  function automatic logic [6:0] bwd(input logic [6:0] d);
    return {d[5:0], d[6] ^ d[2]};
  endfunction

  assign busy     = state == RUN;
  assign sk_valid = state == RUN;
  assign done     = state == DONE;
  assign sk_round = rnd;
  assign wk       = {mk_q[31:0], mk_q[127:96]};
  assign last     = rnd == (ed_q ? 5'(ROUNDS - 1) : 5'd0);

  // lfsr holds the lowest delta of the round when encrypting, the highest when decrypting
  always_comb begin
    j = '0;
    sk = '0;
    dl[0] = lfsr;
    for (int k = 1; k < 4; k++) dl[k] = ed_q ? fwd(dl[k-1]) : bwd(dl[k-1]);
    lfsr_nx = ed_q ? fwd(dl[3]) : bwd(dl[3]);
    for (int m = 0; m < 4; m++) begin
      j = {rnd[0], 2'(m)} - rnd[4:2];
      sk[8*m +: 8] = mk_q[{rnd[1], j, 3'b000} +: 8] + {1'b0, ed_q ? dl[m] : dl[3-m]};
    end
  end

  always_comb
    state_nx = (state == IDLE && start) ? RUN :
               (state == RUN && sk_ready && last) ? DONE :
               (state == DONE) ? IDLE : state;

  always_ff @(posedge clk)
    state <= !reset ? IDLE : state_nx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mk_q <= '0;
      ed_q <= 1'b0;
      lfsr <= '0;
      rnd  <= '0;
    end else if (state == IDLE && start) begin
      mk_q <= mk;
      ed_q <= ed;
      lfsr <= DELTA0;
      rnd  <= ed ? 5'd0 : 5'(ROUNDS - 1);
    end else if (state == RUN && sk_ready && !last) begin
      lfsr <= lfsr_nx;
      rnd  <= ed_q ? rnd + 5'd1 : rnd - 5'd1;
    end
`ifdef HIGHT_KS_ZEROIZE_EN
    else if (state == DONE) begin
      mk_q <= '0;
      lfsr <= '0;
    end
`else
`endif
  end
endmodule
